// File: rtl/gf_mul_512_pkg.sv
// ============================================================================
// gf_mul_512_pkg : shared widths, limb count and FSM encoding for gf_mul_512
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef BW_GF
`define BW_GF 256
`endif
`ifndef PRIME
`define PRIME 256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF
`endif

package gf_mul_512_pkg;

  localparam int GF_BW   = `BW_GF;
  localparam int GF_LIMB = 64;
  localparam int GF_N    = GF_BW / GF_LIMB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } gf_state_t;

endpackage

`default_nettype wire

// File: rtl/gf_limb_mul.sv
// ============================================================================
// gf_limb_mul : combinational W x W -> 2W unsigned limb multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module gf_limb_mul #(
  parameter int W = 64
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);

  assign o_p = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};

endmodule

`default_nettype wire

// File: rtl/gf_mul_512.sv
// ============================================================================
// gf_mul_512 : limb-serial BW x BW -> 2BW unsigned multiplier (shift-add MAC)
// Optional macro GF_MUL_SQR_EN: squaring shortcut (upper-triangle limb pairs).
// Rev 1.0
// ============================================================================
`default_nettype none

module gf_mul_512
  import gf_mul_512_pkg::*;
#(
  parameter int BW   = `BW_GF,
  parameter int LIMB = GF_LIMB
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [BW-1:0]   x,
  input  logic [BW-1:0]   y,
  output logic            busy,
  output logic [2*BW-1:0] product,
  output logic            finish
);

  localparam int N  = BW / LIMB;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(2 * BW);

  gf_state_t         r_state;
  gf_state_t         w_next;
  logic [BW-1:0]     r_x;
  logic [BW-1:0]     r_y;
  logic [2*BW-1:0]   r_acc;
  logic [2*BW-1:0]   r_product;
  logic              r_finish;
  logic [CW-1:0]     r_i;
  logic [CW-1:0]     r_j;
  logic              w_last;
  logic              w_dbl;
  logic [CW:0]       w_ij;
  logic [SW-1:0]     w_shamt;
  logic [2*LIMB-1:0] w_pp;
  logic [2*BW-1:0]   w_pp_ext;
  logic [2*BW-1:0]   w_term;

  gf_limb_mul #(.W(LIMB)) u_limb_mul (
    .i_a (r_x[r_i*LIMB +: LIMB]),
    .i_b (r_y[r_j*LIMB +: LIMB]),
    .o_p (w_pp)
  );

`ifdef GF_MUL_SQR_EN
  logic r_sqr;
  // Squares walk only j >= i; mirrored off-diagonal terms are folded in by doubling.
  assign w_dbl = r_sqr && (r_i != r_j);
`else
  assign w_dbl = 1'b0;
`endif

  assign w_ij     = {1'b0, r_i} + {1'b0, r_j};
  assign w_shamt  = SW'(w_ij * LIMB) + SW'(w_dbl);
  assign w_pp_ext = {{(2*BW-2*LIMB){1'b0}}, w_pp};
  assign w_term   = w_pp_ext << w_shamt;
  assign w_last   = (r_i == CW'(N-1)) && (r_j == CW'(N-1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (valid) w_next = MAC;
      MAC:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_finish  <= 1'b0;
      r_i       <= '0;
      r_j       <= '0;
`ifdef GF_MUL_SQR_EN
      r_sqr     <= 1'b0;
`endif
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        IDLE: begin
          if (valid) begin
            r_x   <= x;
            r_y   <= y;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
`ifdef GF_MUL_SQR_EN
            r_sqr <= (x == y);
`endif
          end
        end
        MAC: begin
          r_acc <= r_acc + w_term;
          if (r_j == CW'(N-1)) begin
            r_i <= r_i + CW'(1);
`ifdef GF_MUL_SQR_EN
            r_j <= r_sqr ? r_i + CW'(1) : '0;
`else
            r_j <= '0;
`endif
          end else begin
            r_j <= r_j + CW'(1);
          end
        end
        DONE: begin
          r_product <= r_acc;
          r_finish  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign product = r_product;
  assign finish  = r_finish;

endmodule

`default_nettype wire

// File: tb/tb_gf_mul_512.sv
// ============================================================================
// tb_gf_mul_512 : vector table, corner sequences and random scoreboard run
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef BW_GF
`define BW_GF 256
`endif
`ifndef PRIME
`define PRIME 256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF
`endif

module tb_gf_mul_512;

  localparam int BW = `BW_GF;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic [BW-1:0]   x;
  logic [BW-1:0]   y;
  logic            busy;
  logic [2*BW-1:0] product;
  logic            finish;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [BW-1:0]   x;
    logic [BW-1:0]   y;
    logic [2*BW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [2*BW-1:0] prod;
    int              start;
    int              lat;
  } sb_t;

  sb_t sb_q[$];

  gf_mul_512 dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .x       (x),
    .y       (y),
    .busy    (busy),
    .product (product),
    .finish  (finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_lat(input logic [BW-1:0] a, input logic [BW-1:0] b);
`ifdef GF_MUL_SQR_EN
    return (a == b) ? 11 : 17;
`else
    return 17;
`endif
  endfunction

  function automatic logic [BW-1:0] rand_op();
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < BW / 32; k++) v = {v[BW-33:0], 32'($urandom)};
    return v;
  endfunction

  // Scoreboard: every finish pops one expected record.
  always @(negedge clk) begin
    if (finish) begin
      sb_t e;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_finish cycle=%0d product=%h", cyc, product);
      end else begin
        e = sb_q.pop_front();
        if (product !== e.prod) begin
          failures++;
          $display("FAIL product got=%h exp=%h", product, e.prod);
        end
        checks++;
        if (cyc - e.start != e.lat) begin
          failures++;
          $display("FAIL latency got=%0d exp=%0d", cyc - e.start, e.lat);
        end
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL busy_at_finish got=%b exp=0", busy);
        end
      end
    end
  end

  task automatic push_exp(input logic [BW-1:0] a, input logic [BW-1:0] b,
                          input logic [2*BW-1:0] p);
    sb_t e;
    e.prod  = p;
    e.start = cyc + 1;
    e.lat   = exp_lat(a, b);
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_%s pending=%0d exp=0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run_op(input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input logic [2*BW-1:0] p);
    bit busy_ok;
    int n;
    @(negedge clk); #1;
    valid = 1'b1; x = a; y = b;
    push_exp(a, b, p);
    @(negedge clk); #1;
    valid = 1'b0;
    busy_ok = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      if (!busy && !finish) busy_ok = 1'b0;
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL timeout pending=%0d exp=0", sb_q.size());
      sb_q.delete();
    end else if (!busy_ok) begin
      failures++;
      $display("FAIL busy_span got=0 exp=1");
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    logic [BW-1:0] ones;
    logic [BW-1:0] a, b;

    ones = '1;
    tbl[0] = '{256'd1, 256'd1, 512'd1};
    tbl[1] = '{ones, ones,
               512'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000001};
    tbl[2] = '{`PRIME, 256'd2,
               512'h1_FFFFFFFE_00000002_00000000_00000000_00000001_FFFFFFFF_FFFFFFFF_FFFFFFFE};
    tbl[3] = '{256'h1234, 256'h10, 512'h12340};
    tbl[4] = '{ones, 256'd0, 512'd0};
    tbl[5] = '{256'd1 << 255, 256'd1 << 255, 512'd1 << 510};

    rst = 1'b1; valid = 1'b0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (finish !== 1'b0) begin failures++; $display("FAIL reset_finish got=%b exp=0", finish); end
    checks++; if (product !== '0)  begin failures++; $display("FAIL reset_product got=%h exp=0", product); end

    for (int i = 0; i < 6; i++) run_op(tbl[i].x, tbl[i].y, tbl[i].exp);

    // Re-pulses at +3 and +17 must be ignored; +18 is accepted.
    a = 256'hDEAD_BEEF_0123_4567; b = 256'h1_0000_0000_0000_0003;
    for (int t = 0; t <= 18; t++) begin
      @(negedge clk); #1;
      valid = 1'b0;
      if (t == 0) begin
        valid = 1'b1; x = a; y = b;
        push_exp(a, b, 512'({256'd0, a} * {256'd0, b}));
      end else if (t == 3 || t == 17) begin
        valid = 1'b1; x = 256'h55; y = 256'h77;
      end else if (t == 18) begin
        valid = 1'b1; x = 256'h9; y = 256'h7;
        push_exp(256'h9, 256'h7, 512'd63);
      end
    end
    @(negedge clk); #1;
    valid = 1'b0;
    wait_drain("repulse");

    // Reset at +8 aborts the operation.
    @(negedge clk); #1;
    valid = 1'b1; x = 256'hABCDEF; y = 256'h12345;
    @(negedge clk); #1;
    valid = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (product !== '0)   begin failures++; $display("FAIL abort_product got=%h exp=0", product); end
    repeat (20) @(negedge clk);
    #1;
    run_op(256'h1234, 256'h10, 512'h12340);

    for (int r = 0; r < 1000; r++) begin
      a = rand_op();
      b = ($urandom_range(9) == 0) ? a : rand_op();
      run_op(a, b, 512'({256'd0, a} * {256'd0, b}));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
